// File: rtl/prog3_mul_engine.sv
// Start/done responder for program 3: reads signed 16-bit operand pairs from byte memory,
// multiplies each over 16 shift-add cycles and writes the 32-bit products back big-endian.
module prog3_mul_engine #(
  parameter int NUM_PAIRS = 16,
  parameter int OP_BASE   = 0,
  parameter int PROD_BASE = 64
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  output logic       done_o,
  output logic       busy_o,
  output logic [7:0] mem_addr_o,
  input  logic [7:0] mem_rd_data_i,
  output logic       mem_wr_en_o,
  output logic [7:0] mem_wr_data_o
);

  localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [PW-1:0] LAST_PAIR = PW'(NUM_PAIRS - 1);
  localparam logic [7:0] OP_BASE8   = 8'(OP_BASE);
  localparam logic [7:0] PROD_BASE8 = 8'(PROD_BASE);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, STORE, DONE} state_t;

  state_t        state_q, state_d;
  logic          start_q;
  logic [PW-1:0] pair_q, pair_d;
  logic [1:0]    byte_q, byte_d;
  logic [3:0]    mulCnt_q, mulCnt_d;
  logic [23:0]   opBytes_q, opBytes_d;
  logic [31:0]   mcand_q, mcand_d;
  logic [15:0]   mplier_q, mplier_d;
  logic [31:0]   prod_q, prod_d;
  logic [7:0]    addrOffset;

  assign addrOffset = 8'({pair_q, byte_q});

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      pair_q    <= '0;
      byte_q    <= '0;
      mulCnt_q  <= '0;
      opBytes_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_i;
      pair_q    <= pair_d;
      byte_q    <= byte_d;
      mulCnt_q  <= mulCnt_d;
      opBytes_q <= opBytes_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
    end
  end

  // Memory-facing outputs decode straight from the registered state so reset silences them at once.
  always_comb begin
    state_d       = state_q;
    pair_d        = pair_q;
    byte_d        = byte_q;
    mulCnt_d      = mulCnt_q;
    opBytes_d     = opBytes_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    prod_d        = prod_q;
    done_o        = 1'b0;
    busy_o        = 1'b0;
    mem_addr_o    = 8'h00;
    mem_wr_en_o   = 1'b0;
    mem_wr_data_o = 8'h00;

    case (state_q)
      IDLE: begin
        if (!start_i && start_q) begin
          state_d = LOAD;
          pair_d  = '0;
          byte_d  = '0;
        end
      end

      LOAD: begin
        busy_o     = 1'b1;
        mem_addr_o = OP_BASE8 + addrOffset;
        opBytes_d  = {opBytes_q[15:0], mem_rd_data_i};
        byte_d     = byte_q + 2'd1;
        if (byte_q == 2'd3) begin
          state_d  = MUL;
          mcand_d  = {{16{opBytes_q[23]}}, opBytes_q[23:8]};
          mplier_d = {opBytes_q[7:0], mem_rd_data_i};
          prod_d   = '0;
          mulCnt_d = '0;
        end
      end

      // Bit 15 of the multiplier carries negative weight, so its partial product is subtracted.
      MUL: begin
        busy_o = 1'b1;
        if (mplier_q[0]) begin
          prod_d = (mulCnt_q == 4'd15) ? (prod_q - mcand_q) : (prod_q + mcand_q);
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        mulCnt_d = mulCnt_q + 4'd1;
        if (mulCnt_q == 4'd15) begin
          state_d = STORE;
          byte_d  = '0;
        end
      end

      STORE: begin
        busy_o        = 1'b1;
        mem_wr_en_o   = 1'b1;
        mem_addr_o    = PROD_BASE8 + addrOffset;
        mem_wr_data_o = prod_q[31:24];
        prod_d        = {prod_q[23:0], 8'h00};
        byte_d        = byte_q + 2'd1;
        if (byte_q == 2'd3) begin
          if (pair_q == LAST_PAIR) begin
            state_d = DONE;
          end else begin
            pair_d  = pair_q + 1'b1;
            state_d = LOAD;
          end
        end
      end

      DONE: begin
        done_o = 1'b1;
        if (start_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog3_mul_engine.sv
// Scoreboard bench for prog3_mul_engine: byte memory model, expected products queued at
// stimulus time and popped by a write monitor as each 4-byte product is stored.
module tb_prog3_mul_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic       busy;
  logic [7:0] memAddr;
  logic [7:0] memRdData;
  logic       memWrEn;
  logic [7:0] memWrData;

  logic       tbWr;
  logic [7:0] tbAddr;
  logic [7:0] tbData;
  logic [7:0] mem [0:255];
  logic [7:0] opImage [0:63];

  typedef struct packed {
    logic [7:0]  q;
    logic [31:0] prod;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          wrCycles = 0;
  int          badWrites = 0;
  int          badAddr = 0;
  logic [15:0] vecA [16];
  logic [15:0] vecB [16];
  logic [31:0] vecP [16];

  prog3_mul_engine dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .done_o        (done),
    .busy_o        (busy),
    .mem_addr_o    (memAddr),
    .mem_rd_data_i (memRdData),
    .mem_wr_en_o   (memWrEn),
    .mem_wr_data_o (memWrData)
  );

  always #5 clk = ~clk;

  assign memRdData = mem[memAddr];

  // Single writer for the memory: DUT stores take priority over bench preloads.
  always @(posedge clk) begin
    if (memWrEn) mem[memAddr] <= memWrData;
    else if (tbWr) mem[tbAddr] <= tbData;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic writeByte(input logic [7:0] addr, input logic [7:0] data);
    tbWr   = 1'b1;
    tbAddr = addr;
    tbData = data;
    @(posedge clk);
    #1 tbWr = 1'b0;
  endtask

  task automatic applyStimulus();
    exp_t e;
    for (int j = 0; j < 16; j++) begin
      opImage[4*j+0] = vecA[j][15:8];
      opImage[4*j+1] = vecA[j][7:0];
      opImage[4*j+2] = vecB[j][15:8];
      opImage[4*j+3] = vecB[j][7:0];
      for (int k = 0; k < 4; k++) writeByte(8'(4*j+k), opImage[4*j+k]);
      e.q    = 8'(64 + 4*j);
      e.prod = vecP[j];
      expQ.push_back(e);
    end
  endtask

  task automatic randomVectors();
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    for (int j = 0; j < 16; j++) begin
      vecA[j] = 16'($urandom);
      vecB[j] = 16'($urandom);
      sa = $signed(vecA[j]);
      sb = $signed(vecB[j]);
      vecP[j] = sa * sb;
    end
  endtask

  task automatic idleWatch(input int cycles, input string name);
    int bad;
    int w0;
    bad = 0;
    w0  = wrCycles;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checkOutput({name, "_no_run"}, 32'(bad), 32'd0);
    checkOutput({name, "_no_write"}, 32'(wrCycles - w0), 32'd0);
  endtask

  task automatic launch();
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("busy_at_launch", 32'(busy), 32'd1);
  endtask

  task automatic runMeasured(input int toggleAt);
    int n;
    int drops;
    int w0;
    int diffs;
    w0 = wrCycles;
    launch();
    n = 0;
    drops = 0;
    while (done !== 1'b1 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
      if (n == toggleAt) start = 1'b1;
      if (n == toggleAt + 1) start = 1'b0;
      if (done !== 1'b1 && busy !== 1'b1) drops++;
    end
    checkOutput("done_edge", 32'(n), 32'd384);
    checkOutput("busy_during_run", 32'(drops), 32'd0);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("write_cycles", 32'(wrCycles - w0), 32'd64);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    checkOutput("writes_in_range", 32'(badWrites), 32'd0);
    checkOutput("addr_in_range", 32'(badAddr), 32'd0);
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== opImage[i]) diffs++;
    checkOutput("operands_unchanged", 32'(diffs), 32'd0);
  endtask

  task automatic releaseDone();
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("done_clears", 32'(done), 32'd0);
  endtask

  // Monitor: assembles each stored product and compares it with the head of the queue.
  initial begin : monitor
    int          byteIdx;
    logic [7:0]  grpAddr;
    logic [31:0] word;
    exp_t        e;
    byteIdx = 0;
    grpAddr = '0;
    word    = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        byteIdx = 0;
      end else begin
        if (busy === 1'b1 && memAddr > 8'd127) badAddr++;
        if (memWrEn === 1'b1) begin
          wrCycles++;
          if (memAddr < 8'd64 || memAddr > 8'd127) badWrites++;
          if (byteIdx == 0) grpAddr = memAddr;
          checkOutput("byte_addr", 32'(memAddr), 32'(grpAddr + 8'(byteIdx)));
          word = {word[23:0], memWrData};
          byteIdx++;
          if (byteIdx == 4) begin
            byteIdx = 0;
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_product actual=0x%08h required=none", word);
            end else begin
              e = expQ.pop_front();
              checkOutput("product_addr", 32'(grpAddr), 32'(e.q));
              checkOutput("product", word, e.prod);
            end
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    tbWr  = 1'b0;
    tbAddr = '0;
    tbData = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_wr_en", 32'(memWrEn), 32'd0);
    checkOutput("reset_addr", 32'(memAddr), 32'd0);
    reset = 1'b0;

    $display("[TB] start held low, then held high");
    idleWatch(40, "start_low");
    start = 1'b1;
    idleWatch(40, "start_high");

    $display("[TB] directed run");
    vecA[0]  = 16'h0003; vecB[0]  = 16'h0005; vecP[0]  = 32'h0000000F;
    vecA[1]  = 16'h8000; vecB[1]  = 16'h8000; vecP[1]  = 32'h40000000;
    vecA[2]  = 16'h7FFF; vecB[2]  = 16'h8000; vecP[2]  = 32'hC0008000;
    vecA[3]  = 16'hFFFF; vecB[3]  = 16'hFFFF; vecP[3]  = 32'h00000001;
    vecA[4]  = 16'hFFFF; vecB[4]  = 16'h0001; vecP[4]  = 32'hFFFFFFFF;
    vecA[5]  = 16'h0000; vecB[5]  = 16'h1234; vecP[5]  = 32'h00000000;
    vecA[6]  = 16'h7FFF; vecB[6]  = 16'h7FFF; vecP[6]  = 32'h3FFF0001;
    vecA[7]  = 16'h0100; vecB[7]  = 16'h0100; vecP[7]  = 32'h00010000;
    vecA[8]  = 16'hFFFE; vecB[8]  = 16'h0003; vecP[8]  = 32'hFFFFFFFA;
    vecA[9]  = 16'h1234; vecB[9]  = 16'h0010; vecP[9]  = 32'h00012340;
    vecA[10] = 16'h8000; vecB[10] = 16'h0001; vecP[10] = 32'hFFFF8000;
    vecA[11] = 16'h8000; vecB[11] = 16'hFFFF; vecP[11] = 32'h00008000;
    vecA[12] = 16'h0002; vecB[12] = 16'hC000; vecP[12] = 32'hFFFF8000;
    vecA[13] = 16'h00FF; vecB[13] = 16'h00FF; vecP[13] = 32'h0000FE01;
    vecA[14] = 16'hFFF6; vecB[14] = 16'h000A; vecP[14] = 32'hFFFFFF9C;
    vecA[15] = 16'h0001; vecB[15] = 16'h7FFF; vecP[15] = 32'h00007FFF;
    applyStimulus();
    runMeasured(-10);
    checkOutput("mem_product0", {mem[64], mem[65], mem[66], mem[67]}, 32'h0000000F);

    $display("[TB] random run with start toggled mid-run");
    releaseDone();
    randomVectors();
    applyStimulus();
    runMeasured(50);

    $display("[TB] reset mid-run then rerun");
    releaseDone();
    randomVectors();
    applyStimulus();
    launch();
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_wr_en", 32'(memWrEn), 32'd0);
    checkOutput("abort_products_left", 32'(expQ.size()), 32'd12);
    expQ.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    start = 1'b0;
    applyStimulus();
    runMeasured(-10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
